wb_regfile: RTL and testbench

- Write-back stage plus architectural register file for the 5-stage pipelined MIPS datapath.
- Sits directly downstream of the MEM/WB pipeline registers and consumes the registered control pair (mem_to_reg, reg_write) with the registered data.
- Selects the write-back value and commits it to a 32x32 register file.
- Provides two combinational read ports to the ID stage and a committed-write counter for debug.

---
 rtl/wb_pkg.sv | 15 +
 rtl/wb_src_mux.sv | 34 +++
 rtl/wb_regfile.sv | 97 +++++++++
 tb/tb_wb_regfile.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared constants for the write-back stage and register file.
//   WB_SRC_* : encodings of the mem_to_reg write-back source select
//   WB_*_W   : default widths for data, register address and commit counter
package wb_pkg;

    localparam logic [1:0] WB_SRC_ALU = 2'b00;
    localparam logic [1:0] WB_SRC_MEM = 2'b01;
    localparam logic [1:0] WB_SRC_PC4 = 2'b10;
    localparam logic [1:0] WB_SRC_RSV = 2'b11;

    localparam int unsigned WB_DATA_W = 32;
    localparam int unsigned WB_ADDR_W = 5;
    localparam int unsigned WB_CNT_W  = 32;

endpackage

// File: rtl/wb_src_mux.sv
// Write-back source select (combinational 4:1).
// Ports:
//   mem_to_reg  in   source select (00 alu, 01 mem, 10 pc+4, 11 reserved)
//   alu_result  in   ALU result
//   mem_data    in   load data
//   pc_plus4    in   link address for jal
//   wb_data     out  selected value, zero for the reserved encoding
//   valid_src   out  low for the reserved encoding
module wb_src_mux
    import wb_pkg::*;
#(
    parameter int unsigned DATA_W = WB_DATA_W
) (
    input  logic [1:0]        mem_to_reg,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [DATA_W-1:0] mem_data,
    input  logic [DATA_W-1:0] pc_plus4,
    output logic [DATA_W-1:0] wb_data,
    output logic              valid_src
);

    // Source decode; reserved encoding yields zero and blocks the commit.
    always_comb begin
        wb_data   = '0;
        valid_src = 1'b1;
        case (mem_to_reg)
            WB_SRC_ALU: wb_data = alu_result;
            WB_SRC_MEM: wb_data = mem_data;
            WB_SRC_PC4: wb_data = pc_plus4;
            default:    valid_src = 1'b0;
        endcase
    end

endmodule

// File: rtl/wb_regfile.sv
// Write-back stage plus architectural register file (2**ADDR_W x DATA_W).
// Optional build macro: WB_BYPASS_EN enables same-cycle write-through on the
// read ports; without it a same-cycle read returns the stored (old) value.
// Ports:
//   clk, rst                 rising-edge clock, synchronous active-high reset
//   reg_write, mem_to_reg    registered MEM/WB control
//   write_reg                destination register index
//   alu_result, mem_data,
//   pc_plus4                 write-back data candidates
//   rs_addr/rs_data,
//   rt_addr/rt_data          combinational read ports (register 0 reads 0)
//   wb_data                  selected write-back value, for forwarding
//   wb_count                 committed writes since reset, wraps
module wb_regfile
    import wb_pkg::*;
#(
    parameter int unsigned DATA_W = WB_DATA_W,
    parameter int unsigned ADDR_W = WB_ADDR_W,
    parameter int unsigned CNT_W  = WB_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              reg_write,
    input  logic [1:0]        mem_to_reg,
    input  logic [ADDR_W-1:0] write_reg,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [DATA_W-1:0] mem_data,
    input  logic [DATA_W-1:0] pc_plus4,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data,
    output logic [DATA_W-1:0] wb_data,
    output logic [CNT_W-1:0]  wb_count
);

    localparam int unsigned NREGS = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs [NREGS];
    logic              valid_src;
    logic              commit;

    wb_src_mux #(
        .DATA_W (DATA_W)
    ) u_src_mux (
        .mem_to_reg (mem_to_reg),
        .alu_result (alu_result),
        .mem_data   (mem_data),
        .pc_plus4   (pc_plus4),
        .wb_data    (wb_data),
        .valid_src  (valid_src)
    );

    // Writes to $0 and reserved-source writes are dropped and not counted.
    assign commit = reg_write & valid_src & (write_reg != '0);

    // Storage and commit counter; reset wins over a same-edge commit.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
            wb_count <= '0;
        end else if (commit) begin
            regs[write_reg] <= wb_data;
            wb_count        <= wb_count + CNT_W'(1);
        end
    end

    // Read port A; $0 is forced to zero regardless of storage.
    always_comb begin
        rs_data = '0;
        if (rs_addr != '0) begin
            rs_data = regs[rs_addr];
        end
`ifdef WB_BYPASS_EN
        // commit already implies write_reg is nonzero
        if (commit && (rs_addr == write_reg)) begin
            rs_data = wb_data;
        end
`endif
    end

    // Read port B, identical to port A.
    always_comb begin
        rt_data = '0;
        if (rt_addr != '0) begin
            rt_data = regs[rt_addr];
        end
`ifdef WB_BYPASS_EN
        if (commit && (rt_addr == write_reg)) begin
            rt_data = wb_data;
        end
`endif
    end

endmodule

// File: tb/tb_wb_regfile.sv
// Directed self-checking bench for wb_regfile. A second instance with a
// 4-bit counter shares all inputs and covers counter wrap.
module tb_wb_regfile;

    logic        clk = 1'b0;
    logic        rst;
    logic        reg_write;
    logic [1:0]  mem_to_reg;
    logic [4:0]  write_reg;
    logic [31:0] alu_result;
    logic [31:0] mem_data;
    logic [31:0] pc_plus4;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic [31:0] rs_data, rt_data, wb_data;
    logic [31:0] wb_count;
    logic [31:0] rs_data_s, rt_data_s, wb_data_s;
    logic [3:0]  wb_count_s;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    wb_regfile u_dut (
        .clk        (clk),
        .rst        (rst),
        .reg_write  (reg_write),
        .mem_to_reg (mem_to_reg),
        .write_reg  (write_reg),
        .alu_result (alu_result),
        .mem_data   (mem_data),
        .pc_plus4   (pc_plus4),
        .rs_addr    (rs_addr),
        .rt_addr    (rt_addr),
        .rs_data    (rs_data),
        .rt_data    (rt_data),
        .wb_data    (wb_data),
        .wb_count   (wb_count)
    );

    wb_regfile #(
        .CNT_W (4)
    ) u_dut_small (
        .clk        (clk),
        .rst        (rst),
        .reg_write  (reg_write),
        .mem_to_reg (mem_to_reg),
        .write_reg  (write_reg),
        .alu_result (alu_result),
        .mem_data   (mem_data),
        .pc_plus4   (pc_plus4),
        .rs_addr    (rs_addr),
        .rt_addr    (rt_addr),
        .rs_data    (rs_data_s),
        .rt_data    (rt_data_s),
        .wb_data    (wb_data_s),
        .wb_count   (wb_count_s)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] exp_hz;

        rst        = 1'b1;
        reg_write  = 1'b0;
        mem_to_reg = 2'b00;
        write_reg  = 5'd0;
        alu_result = 32'h0;
        mem_data   = 32'h0;
        pc_plus4   = 32'h0;
        rs_addr    = 5'd0;
        rt_addr    = 5'd0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state: every register reads zero on both ports.
        for (int i = 0; i < 32; i++) begin
            rs_addr = 5'(i);
            rt_addr = 5'(31 - i);
            #1;
            check($sformatf("rst_rs[%0d]", i), rs_data, 32'h0);
            check($sformatf("rst_rt[%0d]", 31 - i), rt_data, 32'h0);
        end
        check("rst_count", wb_count, 32'd0);
        check("rst_count_s", 32'(wb_count_s), 32'd0);

        // Source select: alu -> r5, mem -> r6, pc+4 -> r31.
        alu_result = 32'h0000_1111;
        mem_data   = 32'h0000_2222;
        pc_plus4   = 32'h0040_0008;
        reg_write  = 1'b1;
        mem_to_reg = 2'b00;
        write_reg  = 5'd5;
        rs_addr    = 5'd0;
        rt_addr    = 5'd0;
        #1;
        check("wbdata_alu", wb_data, 32'h0000_1111);
        tick();
        mem_to_reg = 2'b01;
        write_reg  = 5'd6;
        rs_addr    = 5'd5;
        #1;
        check("wbdata_mem", wb_data, 32'h0000_2222);
        check("r5_alu", rs_data, 32'h0000_1111);
        tick();
        mem_to_reg = 2'b10;
        write_reg  = 5'd31;
        rt_addr    = 5'd6;
        #1;
        check("wbdata_pc4", wb_data, 32'h0040_0008);
        check("r6_mem", rt_data, 32'h0000_2222);
        tick();
        reg_write = 1'b0;
        rs_addr   = 5'd31;
        #1;
        check("r31_pc4", rs_data, 32'h0040_0008);
        check("count_3", wb_count, 32'd3);

        // Write to $0 is dropped and not counted.
        reg_write  = 1'b1;
        mem_to_reg = 2'b00;
        write_reg  = 5'd0;
        alu_result = 32'hDEAD_BEEF;
        rs_addr    = 5'd0;
        #1;
        check("r0_same_cycle", rs_data, 32'h0);
        tick();
        reg_write = 1'b0;
        #1;
        check("r0_after", rs_data, 32'h0);
        check("count_r0", wb_count, 32'd3);

        // Reserved source: wb_data is zero and nothing commits.
        reg_write  = 1'b1;
        mem_to_reg = 2'b11;
        write_reg  = 5'd7;
        rs_addr    = 5'd7;
        #1;
        check("wbdata_rsv", wb_data, 32'h0);
        check("r7_rsv_same", rs_data, 32'h0);
        tick();
        reg_write = 1'b0;
        #1;
        check("r7_rsv_after", rs_data, 32'h0);
        check("count_rsv", wb_count, 32'd3);

        // Same-cycle write/read hazard on r9.
        reg_write  = 1'b1;
        mem_to_reg = 2'b00;
        alu_result = 32'hCAFE_0001;
        write_reg  = 5'd9;
        rs_addr    = 5'd9;
        rt_addr    = 5'd9;
`ifdef WB_BYPASS_EN
        exp_hz = 32'hCAFE_0001;
`else
        exp_hz = 32'h0;
`endif
        #1;
        check("hazard_rs", rs_data, exp_hz);
        check("hazard_rt", rt_data, exp_hz);
        tick();
        reg_write = 1'b0;
        #1;
        check("hazard_rs_next", rs_data, 32'hCAFE_0001);
        check("count_4", wb_count, 32'd4);

        // Reset collides with a commit to r3: write lost, counter cleared.
        reg_write  = 1'b1;
        mem_to_reg = 2'b00;
        alu_result = 32'h1234_5678;
        write_reg  = 5'd3;
        rst        = 1'b1;
        tick();
        rst       = 1'b0;
        reg_write = 1'b0;
        rs_addr   = 5'd3;
        rt_addr   = 5'd9;
        #1;
        check("collide_r3", rs_data, 32'h0);
        check("collide_r9", rt_data, 32'h0);
        check("collide_count", wb_count, 32'd0);
        reg_write = 1'b1;
        tick();
        reg_write = 1'b0;
        #1;
        check("post_rst_r3", rs_data, 32'h1234_5678);
        check("post_rst_count", wb_count, 32'd1);

        // Counter wrap: 17 commits to r1; the 4-bit counter lands on 1.
        rst = 1'b1;
        tick();
        rst        = 1'b0;
        reg_write  = 1'b1;
        mem_to_reg = 2'b00;
        write_reg  = 5'd1;
        for (int i = 0; i < 17; i++) begin
            alu_result = 32'(i);
            tick();
        end
        reg_write = 1'b0;
        rs_addr   = 5'd1;
        rt_addr   = 5'd0;
        #1;
        check("wrap_count32", wb_count, 32'd17);
        check("wrap_count4", 32'(wb_count_s), 32'd1);
        check("wrap_r1", rs_data, 32'd16);
        check("wrap_r1_s", rs_data_s, 32'd16);
        check("wrap_r0_s", rt_data_s, 32'h0);
        check("wrap_wbdata_s", wb_data_s, 32'd16);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
